// File: rtl/instr_fetch_decode.sv
// -----------------------------------------------------------------------------
// instr_fetch_decode
//
// Instruction fetch front end with a 2-entry decode buffer. It issues
// word-aligned fetch requests, captures acknowledged instruction words together
// with their address and immediate-extender select, and presents the oldest
// entry to the downstream stage through a valid/ready handshake. A redirect
// (taken branch/jump) flushes the buffer and restarts fetch at a new target.
//
// Ports
//   CLK              rising-edge clock
//   Reset            asynchronous active-high reset
//   imem_req         fetch request, held until acknowledged
//   imem_addr[31:0]  word-aligned fetch address
//   imem_ack         request accepted; imem_rdata valid this cycle
//   imem_rdata[31:0] fetched instruction word
//   redirect_valid   branch/jump taken: flush and refetch
//   redirect_pc      new fetch target (bits [1:0] ignored)
//   out_valid        head instruction available
//   out_ready        downstream accepts head
//   out_instr        head instruction word (0 when empty)
//   out_pc           head instruction address (0 when empty)
//   out_imm[24:0]    out_instr[31:7], feeds the extender imm port
//   out_extsel[2:0]  extender select for the head instruction
//   out_illegal      head opcode is not in the supported set
// -----------------------------------------------------------------------------
module instr_fetch_decode #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [24:0] out_imm,
  output logic [2:0]  out_extsel,
  output logic        out_illegal
);

  // Supported opcodes (instr[6:0]).
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Extender select encodings.
  localparam logic [2:0] EXT_I  = 3'b000;
  localparam logic [2:0] EXT_S  = 3'b001;
  localparam logic [2:0] EXT_SB = 3'b010;
  localparam logic [2:0] EXT_U  = 3'b011;
  localparam logic [2:0] EXT_UJ = 3'b100;
  localparam logic [2:0] EXT_SH = 3'b101;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  extsel;
    logic        illegal;
  } entry_t;

  logic [31:0] r_pc;          // fetch PC
  logic [1:0]  r_count;       // buffer occupancy, 0..2
  logic        r_redirect_d;  // a redirect happened last cycle
  entry_t      r_fifo [2];    // [0] is always the head

  logic   w_push;
  logic   w_pop;
  entry_t w_new;
  entry_t w_head;

  // Fetch is suppressed while full, during and one cycle after any redirect,
  // and while Reset is held (combinational so it drops without a clock edge).
  assign imem_req  = !Reset && (r_count != 2'd2) && !redirect_valid && !r_redirect_d;
  assign imem_addr = r_pc;

  // imem_req already excludes redirect, so a coincident ack is discarded.
  assign w_push = imem_req && imem_ack;
  assign w_pop  = out_valid && out_ready && !redirect_valid;

  // Decode of the incoming word.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_new.instr   = imem_rdata;
    w_new.pc      = r_pc;
    w_new.extsel  = EXT_I;
    w_new.illegal = 1'b0;
    case (imem_rdata[6:0])
      OP_LOAD, OP_JALR, OP_REG: w_new.extsel = EXT_I;
      OP_IMM: begin
        // Shift-immediate forms (funct3 001 / 101) use the shamt extender.
        if (imem_rdata[13:12] == 2'b01) w_new.extsel = EXT_SH;
      end
      OP_STORE:        w_new.extsel = EXT_S;
      OP_BRANCH:       w_new.extsel = EXT_SB;
      OP_LUI, OP_AUIPC: w_new.extsel = EXT_U;
      OP_JAL:          w_new.extsel = EXT_UJ;
      default:         w_new.illegal = 1'b1;
    endcase
  end

  // Control state: fetch PC, occupancy, redirect history.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_pc         <= PC_RESET;
      r_count      <= 2'd0;
      r_redirect_d <= 1'b0;
    end else begin
      r_redirect_d <= redirect_valid;
      if (redirect_valid) begin
        // Redirect wins over push, pop and PC increment.
        r_count <= 2'd0;
        r_pc    <= redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (w_push) r_pc <= r_pc + 32'd4;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Buffer storage. Entry 0 is the head; a pop shifts entry 1 down.
  // Push+pop together can only happen at count 1 (push needs count<2, pop
  // needs count>0), so the new word lands straight in the head.
  // NOTE: storage is deliberately not reset; r_count qualifies every entry
  // and the outputs are forced to zero when the buffer is empty.
  always_ff @(posedge CLK) begin
    if (w_pop && w_push) begin
      r_fifo[0] <= w_new;
    end else if (w_pop) begin
      r_fifo[0] <= r_fifo[1];
    end else if (w_push) begin
      r_fifo[r_count[0]] <= w_new;
    end
  end

  assign out_valid = (r_count != 2'd0);
  assign w_head    = out_valid ? r_fifo[0] : '0;

  assign out_instr   = w_head.instr;
  assign out_pc      = w_head.pc;
  assign out_extsel  = w_head.extsel;
  assign out_illegal = w_head.illegal;
  assign out_imm     = w_head.instr[31:7];

endmodule

// File: tb/tb_instr_fetch_decode.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_decode
//
// Self-checking bench for instr_fetch_decode. A queue-based reference model
// tracks the fetch PC, buffer contents and redirect history; a compare process
// checks every DUT output against it on each falling edge. Directed sequences
// pin known values, then a randomized phase exercises acks, pops and
// redirects (including back-to-back ones).
// -----------------------------------------------------------------------------
module tb_instr_fetch_decode;

  localparam logic [31:0] PC_RESET = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [24:0] out_imm;
  logic [2:0]  out_extsel;
  logic        out_illegal;

  instr_fetch_decode #(.PC_RESET(PC_RESET)) dut (
    .CLK            (CLK),
    .Reset          (Reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_imm        (out_imm),
    .out_extsel     (out_extsel),
    .out_illegal    (out_illegal)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  extsel;
    logic        illegal;
  } ref_entry_t;

  ref_entry_t  m_q[$];
  logic [31:0] m_pc = PC_RESET;
  logic        m_prev_redirect = 1'b0;

  // Extender select / legality straight from the opcode table.
  function automatic ref_entry_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    ref_entry_t e;
    logic [6:0] op;
    logic [2:0] f3;
    op = w[6:0];
    f3 = w[14:12];
    e.instr = w;
    e.pc = pc;
    e.extsel = 3'd0;
    e.illegal = 1'b0;
    if (op == 7'h03 || op == 7'h67 || op == 7'h33) e.extsel = 3'd0;
    else if (op == 7'h13) e.extsel = (f3 == 3'd1 || f3 == 3'd5) ? 3'd5 : 3'd0;
    else if (op == 7'h23) e.extsel = 3'd1;
    else if (op == 7'h63) e.extsel = 3'd2;
    else if (op == 7'h37 || op == 7'h17) e.extsel = 3'd3;
    else if (op == 7'h6F) e.extsel = 3'd4;
    else e.illegal = 1'b1;
    return e;
  endfunction

  function automatic logic model_req();
    return (m_q.size() < 2) && !redirect_valid && !m_prev_redirect;
  endfunction

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      m_q.delete();
      m_pc = PC_RESET;
      m_prev_redirect = 1'b0;
    end else begin
      logic req_now;
      req_now = model_req();
      if (redirect_valid) begin
        m_q.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
        if (req_now && imem_ack) begin
          m_q.push_back(ref_decode(imem_rdata, m_pc));
          m_pc = m_pc + 32'd4;
        end
      end
      m_prev_redirect = redirect_valid;
    end
  end

  // Compare process: every output, every cycle.
  always @(negedge CLK) begin
    if (Reset) begin
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_addr", imem_addr, PC_RESET);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_instr", out_instr, 32'd0);
      check("rst_pc", out_pc, 32'd0);
    end else begin
      ref_entry_t h;
      if (m_q.size() != 0) h = m_q[0];
      else h = '{instr: 32'd0, pc: 32'd0, extsel: 3'd0, illegal: 1'b0};
      check("req", {31'd0, imem_req}, {31'd0, model_req()});
      check("addr", imem_addr, m_pc);
      check("valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
      check("instr", out_instr, h.instr);
      check("pc", out_pc, h.pc);
      check("imm", {7'd0, out_imm}, h.instr >> 7);
      check("extsel", {29'd0, out_extsel}, {29'd0, h.extsel});
      check("illegal", {31'd0, out_illegal}, {31'd0, h.illegal});
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    imem_ack = 1'b0;
    imem_rdata = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
  endtask

  logic [31:0] stream_w [5];
  logic [2:0]  stream_e [5];
  logic [6:0]  ops [10];

  initial begin
    stream_w[0] = 32'h0020_9463; stream_e[0] = 3'b010;
    stream_w[1] = 32'h0011_2023; stream_e[1] = 3'b001;
    stream_w[2] = 32'h0000_12B7; stream_e[2] = 3'b011;
    stream_w[3] = 32'h0080_006F; stream_e[3] = 3'b100;
    stream_w[4] = 32'h0031_1093; stream_e[4] = 3'b101;
    ops[0] = 7'h03; ops[1] = 7'h67; ops[2] = 7'h13; ops[3] = 7'h23; ops[4] = 7'h63;
    ops[5] = 7'h37; ops[6] = 7'h17; ops[7] = 7'h6F; ops[8] = 7'h33; ops[9] = 7'h7F;

    // Reset held.
    repeat (3) @(posedge CLK);
    sample();
    check("lit_rst_req", {31'd0, imem_req}, 32'd0);
    check("lit_rst_valid", {31'd0, out_valid}, 32'd0);

    // First cycle after release: request at PC_RESET.
    next_cycle(); Reset = 1'b0; idle_inputs();
    sample();
    check("lit_first_req", {31'd0, imem_req}, 32'd1);
    check("lit_first_addr", imem_addr, PC_RESET);

    // Ack one cycle later with addi x1,x0,5.
    next_cycle(); imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    sample();

    // Entry visible the next cycle; memory keeps acking, nobody pops.
    next_cycle(); imem_rdata = 32'h0000_0013;
    sample();
    check("lit_035_valid", {31'd0, out_valid}, 32'd1);
    check("lit_035_pc", out_pc, 32'd0);
    check("lit_035_imm", {7'd0, out_imm}, 32'h0000_A001);
    check("lit_035_extsel", {29'd0, out_extsel}, 32'd0);
    check("lit_035_illegal", {31'd0, out_illegal}, 32'd0);
    check("lit_036_addr4", imem_addr, 32'd4);

    // Full: request drops with address 8 pending, head stays put.
    for (int k = 0; k < 2; k++) begin
      next_cycle(); imem_rdata = 32'hDEAD_BEEF;
      sample();
      check("lit_036_req", {31'd0, imem_req}, 32'd0);
      check("lit_036_addr8", imem_addr, 32'd8);
      check("lit_036_pc", out_pc, 32'd0);
      check("lit_036_instr", out_instr, 32'h0050_0093);
    end

    // Pop once to reach count 1.
    next_cycle(); out_ready = 1'b1;
    sample();

    // Redirect with a coincident ack and pop.
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    sample();
    check("lit_038_cnt1", {31'd0, out_valid}, 32'd1);

    next_cycle(); redirect_valid = 1'b0;
    sample();
    check("lit_038_valid", {31'd0, out_valid}, 32'd0);
    check("lit_038_req_lo", {31'd0, imem_req}, 32'd0);

    next_cycle(); imem_ack = 1'b0;
    sample();
    check("lit_038_req_hi", {31'd0, imem_req}, 32'd1);
    check("lit_038_addr", imem_addr, 32'h0000_0100);

    // Extender-select stream, one word per cycle, consumer always ready.
    for (int i = 0; i <= 5; i++) begin
      next_cycle();
      imem_ack = (i < 5);
      imem_rdata = (i < 5) ? stream_w[i] : 32'd0;
      sample();
      if (i > 0) begin
        check("lit_037_instr", out_instr, stream_w[i-1]);
        check("lit_037_extsel", {29'd0, out_extsel}, {29'd0, stream_e[i-1]});
      end
    end

    // All-ones word is illegal.
    next_cycle(); out_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    sample();
    next_cycle(); imem_ack = 1'b0;
    sample();
    check("lit_039_illegal", {31'd0, out_illegal}, 32'd1);
    check("lit_039_extsel", {29'd0, out_extsel}, 32'd0);

    // Fetch PC wrap: redirect to the last word of the address space.
    next_cycle(); out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    sample();
    next_cycle(); redirect_valid = 1'b0;
    sample();
    next_cycle(); imem_ack = 1'b1; imem_rdata = 32'h0000_0013; out_ready = 1'b0;
    sample();
    check("lit_wrap_addr_hi", imem_addr, 32'hFFFF_FFFC);
    next_cycle(); imem_ack = 1'b0;
    sample();
    check("lit_wrap_addr_lo", imem_addr, 32'd0);
    check("lit_wrap_pc", out_pc, 32'hFFFF_FFFC);

    // Fill to count 2, then assert Reset between clock edges.
    next_cycle(); imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
    next_cycle();
    sample();
    check("lit_040_full", {31'd0, out_valid}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    check("lit_040_valid_async", {31'd0, out_valid}, 32'd0);
    check("lit_040_req_async", {31'd0, imem_req}, 32'd0);
    next_cycle(); Reset = 1'b0; idle_inputs();
    sample();
    check("lit_040_restart_req", {31'd0, imem_req}, 32'd1);
    check("lit_040_restart_addr", imem_addr, PC_RESET);

    // Randomized phase; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] w;
      next_cycle();
      out_ready = ($urandom_range(0, 3) != 0);
      imem_ack = ($urandom_range(0, 2) != 0);
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 9)];
      imem_rdata = w;
      if (redirect_valid) redirect_valid = ($urandom_range(0, 2) == 0);
      else redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
    end

    next_cycle(); idle_inputs();
    sample();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_0000, fetch address loaded on reset.
REQ-002 SHALL use one clock and an asynchronous, active-high reset: CLK  input  1  rising-edge clock.
REQ-003 SHALL have Reset  input  1  asynchronous active-high reset.
REQ-004 SHALL have imem_req  output  1  fetch request, held until acknowledged.
REQ-005 SHALL have imem_addr  output  32  word-aligned fetch address, stable while imem_req is high.
REQ-006 SHALL have imem_ack  input  1  request accepted; imem_rdata valid this cycle.
REQ-007 SHALL have imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-009 SHALL have redirect_pc  input  32  new fetch target; bits [1:0] ignored (treated as 00).
REQ-010 SHALL have out_valid  output  1  head instruction available.
REQ-011 SHALL have out_ready  input  1  downstream accepts head.
REQ-012 SHALL have out_instr  output  32  head instruction word.
REQ-013 SHALL have out_pc  output  32  address of head instruction.
REQ-014 SHALL have out_imm  output  25  immediate field = out_instr[31:7], feeds the extender imm port.
REQ-015 SHALL have out_extsel  output  3  extender select for head instruction.
REQ-016 SHALL have out_illegal  output  1  head opcode not in the supported set.

Function
REQ-017 SHALL hold a 2-entry FIFO of {instr, pc, extsel, illegal}, with count 0..2.
REQ-018 SHALL assert imem_req in every cycle where count<2, no redirect is present in the current or previous cycle, and Reset is low.
REQ-019 SHALL, on imem_req&&imem_ack, push {imem_rdata, imem_addr, decode} and advance fetch PC by 4 (32-bit wrap, FFFF_FFFC -> 0000_0000).
REQ-020 SHALL register pushes: an ack in cycle N makes the entry visible on out_* in cycle N+1.
REQ-021 SHALL pop on out_valid&&out_ready; push and pop in the same cycle leave count unchanged.
REQ-022 SHALL never push when count==2, because imem_req is low at count==2.
REQ-023 SHALL hold out_* stable while out_valid&&!out_ready.
REQ-024 SHALL set out_valid = (count!=0).
REQ-025 SHALL drive out_* from the head entry only while out_valid is high, and SHALL drive out_* to 0 when the FIFO is empty.
REQ-026 SHALL decode extsel from opcode instr[6:0] and funct3:
  - 0000011 or 1100111 -> 000
  - 0010011 -> 101 when funct3 is 001 or 101, else 000
  - 0100011 -> 001
  - 1100011 -> 010
  - 0110111 or 0010111 -> 011
  - 1101111 -> 100
  - 0110011 -> 000
REQ-027 SHALL, for any opcode outside REQ-026, set illegal=1 and extsel=000.
REQ-028 SHALL, on redirect_valid, in that cycle:
  - empty the FIFO (count<=0);
  - discard any coincident ack and any coincident pop;
  - load fetch PC <= {redirect_pc[31:2],2'b00}.
REQ-029 SHALL hold imem_req low in the cycle after a redirect and re-assert it the following cycle at the redirect target.
REQ-030 SHALL give redirect priority over push, pop and PC increment.
REQ-031 SHALL, on back-to-back redirects, use the last target, and imem_req stays low until one cycle after the final redirect.

Reset
REQ-032 SHALL, while Reset is high (asynchronously):
  - set fetch PC = PC_RESET and count = 0;
  - drive imem_req = 0, out_valid = 0;
  - drive out_instr/out_pc/out_imm/out_extsel/out_illegal = 0.
REQ-033 SHALL present imem_req=1, imem_addr=PC_RESET in the first cycle after Reset deasserts.
REQ-034 SHALL lose any request in flight when Reset asserts mid-operation, and SHALL ignore acks during Reset.

Verification
REQ-035 Reset release, ack 1 cycle later with rdata=32'h00500093 -> next cycle out_valid=1, out_pc=0, out_imm=25'h00A001, out_extsel=000, out_illegal=0.
REQ-036 out_ready=0, memory always acks -> two pushes (pc 0, 4), then imem_req=0 with imem_addr=8 pending; count stays 2 and out_* stay stable.
REQ-037 Stream of 0x00209463 (SB), 0x00112023 (S), 0x000012B7 (U), 0x0080006F (UJ), 0x00311093 (shift) -> extsel 010, 001, 011, 100, 101 respectively.
REQ-038 redirect_valid=1, redirect_pc=32'h0000_0103, with imem_ack=1 and count=1 in the same cycle -> next cycle out_valid=0, imem_req=0; following cycle imem_req=1, imem_addr=32'h0000_0100.
REQ-039 rdata=32'hFFFFFFFF -> out_illegal=1, out_extsel=000.
REQ-040 Reset asserted mid-stream, count=2 -> out_valid and imem_req drop immediately (no clock edge needed); restart at PC_RESET.
